// File: rtl/hazard_sensor_conditioner.sv
// Hazard sensor conditioner: four-channel threshold/hysteresis comparison followed
// by a consecutive-sample debounce, producing clean hazard flags and a change pulse.
module hazard_sensor_conditioner #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEB   = 3,
  parameter int unsigned G_ON  = 200,
  parameter int unsigned G_OFF = 150,
  parameter int unsigned S_ON  = 180,
  parameter int unsigned S_OFF = 120,
  parameter int unsigned H_ON  = 220,
  parameter int unsigned H_OFF = 190,
  parameter int unsigned T_ON  = 210,
  parameter int unsigned T_OFF = 170
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sample_valid,
  input  logic [W-1:0] gas,
  input  logic [W-1:0] smoke,
  input  logic [W-1:0] humidity,
  input  logic [W-1:0] temp,
  output logic         IG,
  output logic         IS,
  output logic         IH,
  output logic         IT,
  output logic         changed
);

  localparam int unsigned CW = (DEB > 1) ? $clog2(DEB + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB - 1);

  // Channel order: 0 gas, 1 smoke, 2 humidity, 3 temperature
  localparam logic [3:0][W-1:0] ON_TH  = {W'(T_ON),  W'(H_ON),  W'(S_ON),  W'(G_ON)};
  localparam logic [3:0][W-1:0] OFF_TH = {W'(T_OFF), W'(H_OFF), W'(S_OFF), W'(G_OFF)};

  logic [3:0][W-1:0]  rd;
  logic [3:0]         flag;
  logic [3:0][CW-1:0] cnt;
  logic [3:0]         cand;
  logic [3:0]         toggle;

  assign rd = {temp, humidity, smoke, gas};

  // Hysteresis: the threshold applied depends on the current flag
  always_comb begin
    cand   = '0;
    toggle = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      cand[i]   = flag[i] ? (rd[i] > OFF_TH[i]) : (rd[i] >= ON_TH[i]);
      toggle[i] = sample_valid && (cand[i] != flag[i]) && (cnt[i] == LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag    <= '0;
      cnt     <= '0;
      changed <= 1'b0;
    end else begin
      changed <= |toggle;
      if (sample_valid) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (cand[i] == flag[i]) begin
            cnt[i] <= '0;
          end else if (cnt[i] == LAST) begin
            flag[i] <= ~flag[i];
            cnt[i]  <= '0;
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end
      end
    end
  end

  assign IG = flag[0];
  assign IS = flag[1];
  assign IH = flag[2];
  assign IT = flag[3];

endmodule

// File: tb/tb_hazard_sensor_conditioner.sv
// Directed self-checking bench for hazard_sensor_conditioner (DEB=3 and DEB=1 instances).
module tb_hazard_sensor_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_valid = 1'b0;
  logic [7:0] gas = '0, smoke = '0, humidity = '0, temp = '0;
  logic       IG, IS, IH, IT, changed;

  logic       v1 = 1'b0;
  logic [7:0] g1 = '0;
  logic [7:0] zero8 = '0;
  logic       IG1, IS1, IH1, IT1, changed1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  hazard_sensor_conditioner #(.W(8), .DEB(3)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid),
    .gas(gas), .smoke(smoke), .humidity(humidity), .temp(temp),
    .IG(IG), .IS(IS), .IH(IH), .IT(IT), .changed(changed)
  );

  hazard_sensor_conditioner #(.W(8), .DEB(1)) dut1 (
    .clk(clk), .rst(rst), .sample_valid(v1),
    .gas(g1), .smoke(zero8), .humidity(zero8), .temp(zero8),
    .IG(IG1), .IS(IS1), .IH(IH1), .IT(IT1), .changed(changed1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the capturing edge
  task automatic step(input logic [7:0] g, s, h, t, input logic v);
    gas = g; smoke = s; humidity = h; temp = t; sample_valid = v;
    @(posedge clk); #1;
  endtask

  initial begin
    #1;
    check("rst_flags", {IG, IS, IH, IT}, 4'b0000);
    check("rst_changed", changed, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Mid-streak asynchronous reset on gas
    step(250, 0, 0, 0, 1);
    step(250, 0, 0, 0, 1);
    check("pre_rst_IG", IG, 0);
    rst = 1'b1;
    #2;
    check("async_rst_IG", IG, 0);
    check("async_rst_changed", changed, 0);
    #1 rst = 1'b0;
    step(250, 0, 0, 0, 1);
    step(250, 0, 0, 0, 1);
    check("post_rst_2_IG", IG, 0);
    step(250, 0, 0, 0, 1);
    check("post_rst_3_IG", IG, 1);
    check("post_rst_3_changed", changed, 1);
    step(250, 0, 0, 0, 1);
    check("post_rst_hold_changed", changed, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check("gas_clear_IG", IG, 0);

    // Assert exactly at threshold
    step(200, 0, 0, 0, 1);
    check("g200_1", IG, 0);
    step(200, 0, 0, 0, 1);
    check("g200_2", IG, 0);
    check("g200_2_changed", changed, 0);
    step(200, 0, 0, 0, 1);
    check("g200_3", IG, 1);
    check("g200_3_changed", changed, 1);
    step(0, 0, 0, 0, 0);
    check("g200_pulse_end", changed, 0);
    step(150, 0, 0, 0, 1);
    step(150, 0, 0, 0, 1);
    step(150, 0, 0, 0, 1);
    check("g150_fall", IG, 0);
    for (int i = 0; i < 10; i++) begin
      step(199, 0, 0, 0, 1);
      check("g199_no_assert", IG, 0);
    end

    // Streak broken by a matching sample
    step(0, 0, 0, 210, 1);
    step(0, 0, 0, 210, 1);
    step(0, 0, 0, 100, 1);
    step(0, 0, 0, 210, 1);
    step(0, 0, 0, 210, 1);
    check("t_break_IT", IT, 0);
    step(0, 0, 0, 210, 1);
    check("t_streak_IT", IT, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check("t_clear_IT", IT, 0);

    // Hysteresis band on humidity
    step(0, 0, 220, 0, 1);
    step(0, 0, 220, 0, 1);
    step(0, 0, 220, 0, 1);
    check("h_assert", IH, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 200, 0, 1);
    check("h_band_hold", IH, 1);
    step(0, 0, 190, 0, 1);
    step(0, 0, 190, 0, 1);
    check("h190_2", IH, 1);
    step(0, 0, 190, 0, 1);
    check("h190_3_fall", IH, 0);
    check("h190_3_changed", changed, 1);

    // Gaps in sample_valid; junk on invalid cycles must be ignored
    step(0, 180, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 180, 0, 0, 1);
    check("s_gap_2valid", IS, 0);
    step(0, 0, 0, 0, 0);
    check("s_gap_idle", IS, 0);
    step(0, 180, 0, 0, 1);
    check("s_gap_3valid", IS, 1);
    check("s_gap_changed", changed, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check("s_clear", IS, 0);

    // Simultaneous toggle on gas and smoke
    step(255, 255, 0, 0, 1);
    step(255, 255, 0, 0, 1);
    check("sim_2_changed", changed, 0);
    step(255, 255, 0, 0, 1);
    check("sim_flags", {IG, IS, IH, IT}, 4'b1100);
    check("sim_changed", changed, 1);
    step(255, 255, 0, 0, 0);
    check("sim_changed_end", changed, 0);

    // DEB=1 instance
    check("deb1_idle", IG1, 0);
    g1 = 200; v1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0;
    check("deb1_IG", IG1, 1);
    check("deb1_changed", changed1, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1);
  end

endmodule
